// File: rtl/slice_adder_pkg.sv
// Shared types and derived constants for the slice adder controller.
// Holds the FSM state encoding and the slice-count/index-width helpers.
package slice_adder_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_SLICE   = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int nslices(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_operand_shifter.sv
// Operand/result shift registers: presents the current slice at bits [SLICE-1:0], shifts on each completed slice.
// Latency: one cycle per shift; no backpressure, controlled entirely by load/shift strobes.
module slice_operand_shifter #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  input  logic [SLICE-1:0] sum_in,
  output logic [SLICE-1:0] a_lo,
  output logic [SLICE-1:0] b_lo,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_ext;

  assign sum_ext = WIDTH'(sum_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
    end else if (load) begin
      a_reg  <= ld_a;
      b_reg  <= ld_b;
      result <= '0;
    end else if (shift) begin
      a_reg  <= a_reg >> SLICE;
      b_reg  <= b_reg >> SLICE;
      // New slice enters at the top; after NSLICES shifts the LS slice is at the bottom.
      result <= (result >> SLICE) | (sum_ext << (WIDTH - SLICE));
    end
  end

  assign a_lo = a_reg[SLICE-1:0];
  assign b_lo = b_reg[SLICE-1:0];

endmodule

// File: rtl/slice_adder_controller.sv
// Issues a WIDTH-bit add/sub slice by slice to one SLICE-bit adder; result after NSLICES*(1+L)+1 cycles.
// One request in flight; req_ready low until the response is consumed. Optional SLICE_TIMEOUT_EN aborts stalled slices.
module slice_adder_controller
  import slice_adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SLICE   = DEF_SLICE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_ovf,
  output logic             resp_err,
  output logic [SLICE-1:0] slc_a,
  output logic [SLICE-1:0] slc_b,
  output logic             slc_cin,
  output logic             slc_start,
  input  logic [SLICE-1:0] slc_sum,
  input  logic             slc_cout,
  input  logic             slc_complete
);

  localparam int NSLICES = nslices(WIDTH, SLICE);
  localparam int IW      = idx_width(NSLICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICES - 1);

  if ((WIDTH % SLICE) != 0 || TIMEOUT < 1) begin : g_cfg_err
    $error("slice_adder_controller: WIDTH must be a multiple of SLICE and TIMEOUT >= 1");
  end

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            sub_q;
  logic            a_msb;
  logic            beff_msb;
  logic            load;
  logic            shift;
  logic            timeout;
  logic            err_q;
  logic [SLICE-1:0] a_lo;
  logic [SLICE-1:0] b_lo;
  logic [WIDTH-1:0] result;

  slice_operand_shifter #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) u_shifter (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .ld_a   (op_a),
    .ld_b   (op_b),
    .sum_in (slc_sum),
    .a_lo   (a_lo),
    .b_lo   (b_lo),
    .result (result)
  );

`ifdef SLICE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout = (state == WAIT) && !slc_complete && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout)
        err_q <= 1'b1;
      else if (state == DONE && resp_ready)
        err_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    shift      = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    slc_start  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        slc_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (slc_complete) begin
          shift    = 1'b1;
          state_nx = (idx == LAST_IDX) ? DONE : ISSUE;
        end else if (timeout) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Carry chain and the MSBs needed for signed overflow once the operands have shifted out.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      a_msb    <= 1'b0;
      beff_msb <= 1'b0;
    end else if (load) begin
      idx      <= '0;
      carry    <= op_sub;
      sub_q    <= op_sub;
      a_msb    <= op_a[WIDTH-1];
      beff_msb <= op_b[WIDTH-1] ^ op_sub;
    end else if (shift) begin
      carry <= slc_cout;
      if (idx != LAST_IDX)
        idx <= idx + 1'b1;
    end
  end

  assign slc_a     = a_lo;
  assign slc_b     = b_lo ^ {SLICE{sub_q}};
  assign slc_cin   = carry;
  assign resp_sum  = err_q ? '0 : result;
  assign resp_cout = carry & ~err_q;
  assign resp_ovf  = ~err_q & (a_msb == beff_msb) & (result[WIDTH-1] != a_msb);
  assign resp_err  = err_q;

endmodule

// File: tb/tb_slice_adder_controller.sv
// Scoreboard bench for slice_adder_controller with a behavioural slice adder of configurable latency.
module tb_slice_adder_controller;

  localparam int W  = 64;
  localparam int S  = 8;
  localparam int NS = W / S;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          op_sub = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [W-1:0]  resp_sum;
  logic          resp_cout, resp_ovf, resp_err;
  logic [S-1:0]  slc_a, slc_b, slc_sum;
  logic          slc_cin, slc_start, slc_cout, slc_complete;

  always #5 clock = ~clock;

  slice_adder_controller #(.WIDTH(W), .SLICE(S), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin), .slc_start(slc_start),
    .slc_sum(slc_sum), .slc_cout(slc_cout), .slc_complete(slc_complete)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   exp_lat = -1;
  int   mode = 0;       // 0: L=2, 1: random L 1..4, 2: never completes
  int   starts = 0;
  int   slice_k = 0;
  logic [W-1:0] cur_a = '0, cur_beff = '0;
  logic cur_sub = 1'b0;
  logic rand_rr = 1'b0;
  logic prev_rv = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural slice adder: complete pulses in the L-th cycle after the start pulse.
  logic [S-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  int           m_n = 0;
  always @(posedge clock) begin
    if (slc_start) begin
      {m_cout, m_sum} <= 9'(slc_a) + 9'(slc_b) + 9'(slc_cin);
      m_n <= (mode == 2) ? 0 : (mode == 1) ? int'($urandom_range(1, 4)) : 2;
    end else if (m_n > 0) begin
      m_n <= m_n - 1;
    end
  end
  assign slc_complete = (m_n == 1);
  assign slc_sum      = m_sum;
  assign slc_cout     = m_cout;

  always @(posedge clock) begin
    #1;
    if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] sum, input logic cout, input logic ovf, input logic err);
    exp_t e;
    e.sum = sum; e.cout = cout; e.ovf = ovf; e.err = err;
    return e;
  endfunction

  // Plain arithmetic reference: modular sum, unsigned carry/no-borrow, signed range check.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    logic signed [W+1:0] sa, sb, sr;
    logic [W:0] u;
    sa = {{2{a[W-1]}}, a};
    sb = {{2{b[W-1]}}, b};
    sr = sub ? (sa - sb) : (sa + sb);
    u  = {1'b0, a} + {1'b0, b};
    e.sum  = sub ? (a - b) : (a + b);
    e.cout = sub ? (a >= b) : u[W];
    e.ovf  = (sr[W+1:W-1] != 3'b000) && (sr[W+1:W-1] != 3'b111);
    e.err  = 1'b0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input exp_t e);
    int w = 0;
    @(posedge clock); #1;
    op_a = a; op_b = b; op_sub = sub; req_valid = 1'b1;
    @(negedge clock);
    while (!req_ready && w < 3000) begin
      @(negedge clock);
      w++;
    end
    check("accept_wait", 64'(w >= 3000), 64'd0);
    if (w < 3000) begin
      exp_q.push_back(e);
      acc_cyc  = cyc;
      slice_k  = 0;
      starts   = 0;
      cur_a    = a;
      cur_beff = sub ? ~b : b;
      cur_sub  = sub;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int w = 0;
    while ((exp_q.size() != 0 || !req_ready) && w < maxc) begin
      @(negedge clock);
      w++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: slice-issue checks and response scoreboard.
  always @(negedge clock) begin
    exp_t e;
    logic [W:0]   low;
    logic [W-1:0] m;
    if (!reset && slc_start) begin
      if (slice_k >= NS) begin
        check("extra_slc_start", 64'(slice_k), 64'(NS - 1));
      end else begin
        m   = (64'h1 << (S * slice_k)) - 64'h1;
        low = {1'b0, cur_a & m} + {1'b0, cur_beff & m} + 65'(cur_sub);
        check("slc_a", 64'(slc_a), 64'(cur_a[S*slice_k +: S]));
        check("slc_b", 64'(slc_b), 64'(cur_beff[S*slice_k +: S]));
        check("slc_cin", 64'(slc_cin), 64'(low[S*slice_k]));
      end
      slice_k++;
      starts++;
    end
    if (resp_valid && !prev_rv && exp_lat >= 0)
      check("resp_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
    prev_rv = resp_valid;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got sum 0x%0h, expected no response", resp_sum);
      end else begin
        e = exp_q.pop_front();
        check("resp_sum", resp_sum, e.sum);
        check("resp_cout", 64'(resp_cout), 64'(e.cout));
        check("resp_ovf", 64'(resp_ovf), 64'(e.ovf));
        check("resp_err", 64'(resp_err), 64'(e.err));
        if (!e.err) check("slc_start_count", 64'(starts), 64'(NS));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    logic         rs;
    int           w;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_sum", resp_sum, 64'd0);
    check("rst_resp_cout", 64'(resp_cout), 64'd0);
    check("rst_resp_ovf", 64'(resp_ovf), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_slc_start", 64'(slc_start), 64'd0);
    check("rst_slc_a", 64'(slc_a), 64'd0);
    check("rst_slc_b", 64'(slc_b), 64'd0);
    check("rst_slc_cin", 64'(slc_cin), 64'd0);

    // Directed cases with fixed L=2
    mode = 0;
    exp_lat = NS * 3 + 1;
    send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, mk(64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0));
    drain(200);
    send(64'd5, 64'd7, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0));
    drain(200);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
    drain(200);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b0));
    drain(200);

    // Reset while waiting on slice 3; its late complete must be ignored
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
         ref_model(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0));
    w = 0;
    while (starts < 4 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("reset_setup_wait", 64'(starts), 64'd4);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_slc_start", 64'(slc_start), 64'd0);
    repeat (5) @(negedge clock);
    check("late_cpl_req_ready", 64'(req_ready), 64'd1);
    check("late_cpl_resp_valid", 64'(resp_valid), 64'd0);
    send(64'd2, 64'd3, 1'b0, mk(64'd5, 1'b0, 1'b0, 1'b0));
    drain(200);

    // Hold response under backpressure while extra requests are offered
    resp_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
         mk(64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0));
    w = 0;
    while (!resp_valid && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    held = resp_sum;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      req_valid = (i % 2 == 0);
      op_a = {$urandom, $urandom};
      @(negedge clock);
      check("bp_sum_stable", resp_sum, held);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_valid_held", 64'(resp_valid), 64'd1);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain(50);
    repeat (30) @(negedge clock);
    check("bp_no_extra_req", 64'(req_ready), 64'd1);

    // Randomized operands, slice latency and response backpressure
    mode = 1;
    exp_lat = -1;
    rand_rr = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        1: rb = 64'h8000_0000_0000_0000;
        2: rb = ra;
        default: ;
      endcase
      send(ra, rb, rs, ref_model(ra, rb, rs));
    end
    drain(3000);
    rand_rr = 1'b0;
    @(posedge clock); #1 resp_ready = 1'b1;

    // Slice adder that never completes
    mode = 2;
`ifdef SLICE_TIMEOUT_EN
    exp_lat = 17;
    send(64'hDEAD_BEEF_0000_0001, 64'h2, 1'b0, mk(64'h0, 1'b0, 1'b0, 1'b1));
    drain(200);
    check("tmo_err_cleared", 64'(resp_err), 64'd0);
`else
    exp_lat = -1;
    send(64'hDEAD_BEEF_0000_0001, 64'h2, 1'b0, mk(64'h0, 1'b0, 1'b0, 1'b0));
    repeat (1000) @(negedge clock);
    check("hang_resp_valid", 64'(resp_valid), 64'd0);
    check("hang_resp_err", 64'(resp_err), 64'd0);
    check("hang_req_ready", 64'(req_ready), 64'd0);
    check("hang_one_start", 64'(starts), 64'd1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("hang_rst_req_ready", 64'(req_ready), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slice_adder_controller.md
Name: slice_adder_controller

Overview:
- Initiator side of the slice adder start/complete handshake.
- Accepts a WIDTH-bit add/subtract request and issues it slice by slice, least-significant slice first, to one SLICE-bit slice adder.
- Chains the carry between slices in its own register, then assembles sum, carry-out and signed overflow.
- Sits between the host request interface and the existing slice adders, so narrow adders can compute wide operands.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SLICE.
- SLICE, 8, slice adder width.
- TIMEOUT, 15, maximum WAIT cycles per slice. Used only with SLICE_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted on req_valid&&req_ready
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- op_sub  in  1  1 = A-B, 0 = A+B
- resp_valid  out  1  result available; held until resp_ready
- resp_ready  in  1  host consumes result
- resp_sum  out  WIDTH  result
- resp_cout  out  1  final carry-out (for sub: 1 = no borrow)
- resp_ovf  out  1  signed overflow
- resp_err  out  1  slice timeout abort; tied 0 without SLICE_TIMEOUT_EN
- slc_a  out  SLICE  slice operand A
- slc_b  out  SLICE  slice operand B, already inverted for sub
- slc_cin  out  1  slice carry-in
- slc_start  out  1  one-cycle start pulse
- slc_sum  in  SLICE  slice sum
- slc_cout  in  1  slice carry-out
- slc_complete  in  1  slice result valid

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, resp_err=0, slc_start=0, slc_a/slc_b/slc_cin=0, slice index=0, carry register=0.
- Reset mid-operation: the next cycle is IDLE with reset values. Any slc_complete arriving afterwards is ignored.
- NSLICES = WIDTH/SLICE.
- IDLE state:
  - req_ready=1.
  - On acceptance, latch op_a, op_b and op_sub.
  - carry <= op_sub, index <= 0, go to ISSUE.
- ISSUE state (exactly 1 cycle):
  - slc_start=1.
  - slc_a = A[index*SLICE +: SLICE].
  - slc_b = B slice XOR {SLICE{op_sub}}.
  - slc_cin = carry.
  - Go to WAIT.
- WAIT state:
  - slc_start=0; slc_a, slc_b and slc_cin are held stable.
  - slc_complete is sampled only in WAIT.
  - On slc_complete=1: store slc_sum into the result slice and set carry <= slc_cout.
  - If index==NSLICES-1, go to DONE; otherwise index++ and go to ISSUE.
- DONE state:
  - resp_valid=1, with resp_sum, resp_cout and resp_ovf stable.
  - resp_cout = final carry.
  - resp_ovf = (A[MSB] == Beff[MSB]) && (sum[MSB] != A[MSB]), where Beff is B after inversion.
  - On resp_ready, go to IDLE; req_ready rises the following cycle.
- No back-to-back overlap: req_ready=0 in ISSUE, WAIT and DONE. req_valid in those states is ignored, not queued.
- Latency: if complete is seen in the L-th WAIT cycle, each slice costs 1+L cycles. resp_valid rises NSLICES*(1+L)+1 cycles after the acceptance edge.
- Wrap-around: sums are modulo 2^WIDTH; the carry is reported only through resp_cout.

Optional Feature:
- Macro: SLICE_TIMEOUT_EN.
- Defined:
  - A per-slice counter clears in ISSUE and increments in WAIT.
  - If it reaches TIMEOUT without slc_complete, go to DONE with resp_err=1, resp_sum=0, resp_cout=0, resp_ovf=0.
  - resp_err clears on leaving DONE.
- Undefined:
  - No counter; WAIT persists indefinitely; resp_err is constant 0.

Decomposition:
- Package slice_adder_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - NSLICES and index-width derivation;
  - default WIDTH, SLICE, TIMEOUT constants.
- One natural sub-module, slice_operand_shifter:
  - holds A and B plus the result register;
  - shifts A and B right by SLICE after each completed slice;
  - shifts slc_sum in at the top, so slices are always read from bits [SLICE-1:0].
- FSM, carry and overflow logic live in the top module.

Test Plan:
All cases use WIDTH=64, SLICE=8 and a behavioural slice model with L=2.
1. Add 0x00000000_FFFFFFFF + 0x1 -> resp_sum=0x00000001_00000000, cout=0, ovf=0; 8 slc_start pulses; resp_valid 25 cycles after acceptance.
2. Sub 5 - 7 -> first slice slc_b=0xF8, slc_cin=1; resp_sum=0xFFFFFFFF_FFFFFFFE, cout=0, ovf=0.
3. Add 0x7FFFFFFF_FFFFFFFF + 1 -> sum=0x80000000_00000000, ovf=1, cout=0. Add 0xFFFFFFFF_FFFFFFFF + 1 -> sum=0, cout=1, ovf=0.
4. Reset high for one cycle during slice 3 WAIT -> next cycle IDLE, req_ready=1, resp_valid=0. A late slc_complete is ignored. A following add 2+3 gives 5.
5. resp_ready low for 5 cycles in DONE, with req_valid pulsed meanwhile -> resp_sum stable, req_ready=0, extra request not accepted. Result consumed when resp_ready=1.
6. Slice model never completes:
   - with SLICE_TIMEOUT_EN, resp_valid=1, resp_err=1, sum=0 after 15 WAIT cycles;
   - without it, still in WAIT after 1000 cycles, resp_err=0.
